// File: rtl/svfloat_itof_pipe_if.sv
// rtl/svfloat_itof_pipe_if.sv - float formats and the stream bundle of the integer-to-float pipe
// Input stream carries operand/signedness/rounding mode; output stream carries packed float plus flags.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;

  typedef struct packed {
    logic       sign;
    logic [4:0] exponent;
    logic [9:0] mantissa;
  } float16;
endpackage

interface svfloat_itof_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DW    = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_signed;
  logic [2:0]       in_rm;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_data, in_signed, in_rm, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_rm, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/svfloat_itof_pipe.sv
// rtl/svfloat_itof_pipe.sv - three-stage back-pressured fixed-point to float converter
// Stages: sign/magnitude conditioning, leading-one normalisation, round and pack with IEEE flags.
module svfloat_itof_pipe #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0
) (
  input logic                clk,
  input logic                rst,
  svfloat_itof_pipe_if.slave bus_io
);
  localparam float FZ   = '0;
  localparam int   E    = $bits(FZ.exponent);
  localparam int   M    = $bits(FZ.mantissa);
  localparam int   BIAS = (1 << (E - 1)) - 1;
  localparam int   EMAX = (1 << E) - 1;
  localparam int   PW   = $clog2(width);
  localparam int   CW   = PW + 1;
  // One spare bit beyond the exponent range keeps eb + carry free of wrap-around.
  localparam int   XW   = ((CW > E + 2) ? CW : E + 2) + 1;
  localparam int   L    = width + M + 2;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic v1_q, v2_q, v3_q;
  logic ready1, ready2, ready3;

  logic             s1_sign_q, s1_sign_d;
  logic [width-1:0] s1_mag_q, s1_mag_d;
  logic [2:0]       s1_rm_q, s1_rm_d;

  logic                 s2_sign_q;
  logic [2:0]           s2_rm_q;
  logic                 s2_zero_q, s2_zero_d;
  logic signed [XW-1:0] s2_exp_q, s2_exp_d;
  logic [width-1:0]     s2_norm_q, s2_norm_d;

  float       res_q, res_d;
  logic [2:0] flags_q, flags_d;

  assign ready3 = !v3_q | bus_io.out_ready;
  assign ready2 = !v2_q | ready3;
  assign ready1 = !v1_q | ready2;

  assign bus_io.in_ready  = ready1;
  assign bus_io.out_valid = v3_q;
  assign bus_io.out_data  = res_q;
  assign bus_io.out_flags = flags_q;

  always_comb begin
    s1_sign_d = bus_io.in_signed & bus_io.in_data[width-1];
    s1_mag_d  = s1_sign_d ? -bus_io.in_data : bus_io.in_data;
    s1_rm_d   = (bus_io.in_rm > RM_RMM) ? RM_RNE : bus_io.in_rm;
  end

  logic [PW-1:0] msb_idx;

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < width; i++) begin
      if (s1_mag_q[i]) msb_idx = PW'(i);
    end
    s2_zero_d = (s1_mag_q == '0);
    s2_norm_d = s1_mag_q << (PW'(width - 1) - msb_idx);
    s2_exp_d  = XW'(msb_idx) - XW'(frac);
  end

  logic signed [XW-1:0] eb;
  logic [XW-1:0]        sh, eb_r;
  logic [L-1:0]         xv;
  logic [L-2:0]         xs;
  logic [M-1:0]         mant, mant_r;
  logic                 tiny, lost, guard, sticky, inc, carry, ovf, inexact, sat;

  always_comb begin
    eb   = s2_exp_q + XW'(BIAS);
    tiny = eb[XW-1] | (eb == '0);
    sh   = tiny ? (XW'(1) - $unsigned(eb)) : '0;
    // Subnormals shift the hidden bit into the fraction; bits pushed out still count as sticky.
    xv     = {s2_norm_q, {(M + 2){1'b0}}};
    lost   = |(xv & ~({L{1'b1}} << sh));
    xs     = (L - 1)'(xv >> sh);
    mant   = xs[L-2 -: M];
    guard  = xs[L-2-M];
    sticky = (|xs[L-3-M:0]) | lost;

    case (s2_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & s2_sign_q;
      RM_RUP:  inc = (guard | sticky) & !s2_sign_q;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase

    {carry, mant_r} = {1'b0, mant} + {{M{1'b0}}, inc};
    eb_r    = (tiny ? '0 : $unsigned(eb)) + XW'(carry);
    ovf     = (eb_r >= XW'(EMAX));
    inexact = guard | sticky | ovf;
    sat     = (s2_rm_q == RM_RTZ) | ((s2_rm_q == RM_RDN) & !s2_sign_q) |
              ((s2_rm_q == RM_RUP) & s2_sign_q);

    res_d.sign     = s2_sign_q;
    res_d.exponent = eb_r[E-1:0];
    res_d.mantissa = mant_r;
    flags_d        = {ovf, tiny & inexact, inexact};

    if (ovf) begin
      if (sat) begin
        res_d.exponent = {{(E - 1){1'b1}}, 1'b0};
        res_d.mantissa = {M{1'b1}};
      end else begin
        res_d.exponent = {E{1'b1}};
        res_d.mantissa = '0;
      end
    end

    if (s2_zero_q) begin
      res_d   = '0;
      flags_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_rm_q   <= '0;
      s2_sign_q <= 1'b0;
      s2_rm_q   <= '0;
      s2_zero_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_norm_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      if (ready1) begin
        v1_q <= bus_io.in_valid;
        if (bus_io.in_valid) begin
          s1_sign_q <= s1_sign_d;
          s1_mag_q  <= s1_mag_d;
          s1_rm_q   <= s1_rm_d;
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_sign_q <= s1_sign_q;
          s2_rm_q   <= s1_rm_q;
          s2_zero_q <= s2_zero_d;
          s2_exp_q  <= s2_exp_d;
          s2_norm_q <= s2_norm_d;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_svfloat_itof_pipe.sv
// tb/tb_svfloat_itof_pipe.sv - scoreboard bench for svfloat_itof_pipe
// Three instances: float32/frac 0, float16/frac 0, float16/frac 30.
module tb_svfloat_itof_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [34:0] q32[$];
  logic [34:0] q16a[$];
  logic [34:0] q16b[$];

  logic [31:0] ival [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  svfloat_itof_pipe_if #(.WIDTH(32), .DW(32)) b32 ();
  svfloat_itof_pipe_if #(.WIDTH(32), .DW(16)) b16a ();
  svfloat_itof_pipe_if #(.WIDTH(32), .DW(16)) b16b ();

  svfloat_itof_pipe #(.float(svfloat::float32), .width(32), .frac(0))
    u32 (.clk(clk), .rst(rst), .bus_io(b32));
  svfloat_itof_pipe #(.float(svfloat::float16), .width(32), .frac(0))
    u16a (.clk(clk), .rst(rst), .bus_io(b16a));
  svfloat_itof_pipe #(.float(svfloat::float16), .width(32), .frac(30))
    u16b (.clk(clk), .rst(rst), .bus_io(b16b));

  function automatic void chk(input string nm, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL f32_unexpected got=%h", b32.out_data);
      end else chk("f32_out", {b32.out_flags, b32.out_data}, q32.pop_front());
    end
    if (!rst && b16a.out_valid && b16a.out_ready) begin
      if (q16a.size() == 0) begin
        checks++; errors++;
        $display("FAIL f16a_unexpected got=%h", b16a.out_data);
      end else chk("f16a_out", {b16a.out_flags, 16'h0, b16a.out_data}, q16a.pop_front());
    end
    if (!rst && b16b.out_valid && b16b.out_ready) begin
      if (q16b.size() == 0) begin
        checks++; errors++;
        $display("FAIL f16b_unexpected got=%h", b16b.out_data);
      end else chk("f16b_out", {b16b.out_flags, 16'h0, b16b.out_data}, q16b.pop_front());
    end
  end

  task automatic drive(input int d, input logic v, input logic [31:0] data,
                       input logic sgn, input logic [2:0] rm);
    case (d)
      0: begin b32.in_valid = v; b32.in_data = data; b32.in_signed = sgn; b32.in_rm = rm; end
      1: begin b16a.in_valid = v; b16a.in_data = data; b16a.in_signed = sgn; b16a.in_rm = rm; end
      default: begin b16b.in_valid = v; b16b.in_data = data; b16b.in_signed = sgn; b16b.in_rm = rm; end
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return b32.in_ready;
      1: return b16a.in_ready;
      default: return b16b.in_ready;
    endcase
  endfunction

  task automatic push(input int d, input logic [31:0] data, input logic sgn,
                      input logic [2:0] rm, input logic [34:0] exp);
    int n;
    n = 0;
    drive(d, 1'b1, data, sgn, rm);
    @(negedge clk);
    while (!rdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(d)) begin
      checks++; errors++;
      $display("FAIL push_timeout dut=%0d got=in_ready_low expected=in_ready_high", d);
      drive(d, 1'b0, '0, 1'b0, '0);
      return;
    end
    @(posedge clk);
    case (d)
      0: q32.push_back(exp);
      1: q16a.push_back(exp);
      default: q16b.push_back(exp);
    endcase
    #1;
  endtask

  task automatic idle_all();
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    drive(2, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic latency_check(input string nm);
    push(0, 32'd3, 1'b0, 3'd0, {3'b000, 32'h40400000});
    idle_all();
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_c2"}, 35'(b32.out_valid), 35'(0));
    @(negedge clk);
    chk({nm, "_c3"}, 35'(b32.out_valid), 35'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    b32.out_ready = 1'b1;
    b16a.out_ready = 1'b1;
    b16b.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_in_ready", 35'(b32.in_ready), 35'(1));
    chk("reset_out_valid", 35'(b32.out_valid), 35'(0));
    chk("reset_out", {b32.out_flags, b32.out_data}, 35'(0));
    @(posedge clk);
    #1;

    push(0, 32'h00000001, 1'b0, 3'd0, {3'b000, 32'h3F800000});
    push(0, 32'hFFFFFFFF, 1'b1, 3'd0, {3'b000, 32'hBF800000});
    push(0, 32'hFFFFFFFF, 1'b0, 3'd0, {3'b001, 32'h4F800000});
    push(0, 32'hFFFFFFFF, 1'b0, 3'd1, {3'b001, 32'h4F7FFFFF});
    push(0, 32'hFFFFFFFF, 1'b0, 3'd3, {3'b001, 32'h4F800000});
    push(0, 32'hFFFFFFFF, 1'b0, 3'd4, {3'b001, 32'h4F800000});
    push(0, 32'hFFFFFFFF, 1'b0, 3'd2, {3'b001, 32'h4F7FFFFF});
    push(0, 32'h80000000, 1'b1, 3'd0, {3'b000, 32'hCF000000});
    push(0, 32'h00000000, 1'b0, 3'd2, {3'b000, 32'h00000000});
    push(0, 32'h7FFFFFFF, 1'b0, 3'd7, {3'b001, 32'h4F000000});
    push(0, 32'h80000001, 1'b1, 3'd2, {3'b001, 32'hCF000000});
    push(0, 32'h80000001, 1'b1, 3'd3, {3'b001, 32'hCEFFFFFF});
    push(0, 32'h80000001, 1'b1, 3'd1, {3'b001, 32'hCEFFFFFF});
    idle_all();

    push(1, 32'h00010000, 1'b0, 3'd0, {3'b101, 32'h7C00});
    push(1, 32'h00010000, 1'b0, 3'd1, {3'b101, 32'h7BFF});
    push(1, 32'h00010000, 1'b0, 3'd2, {3'b101, 32'h7BFF});
    push(1, 32'h00010000, 1'b0, 3'd3, {3'b101, 32'h7C00});
    push(1, 32'hFFFF0000, 1'b1, 3'd2, {3'b101, 32'hFC00});
    push(1, 32'hFFFF0000, 1'b1, 3'd3, {3'b101, 32'hFBFF});
    push(1, 32'h0000FFE0, 1'b0, 3'd0, {3'b000, 32'h7BFF});
    push(1, 32'h0000FFF0, 1'b0, 3'd0, {3'b101, 32'h7C00});
    idle_all();

    push(2, 32'h00000001, 1'b0, 3'd0, {3'b011, 32'h0000});
    push(2, 32'h00000001, 1'b0, 3'd3, {3'b011, 32'h0001});
    push(2, 32'h0000FFFF, 1'b0, 3'd0, {3'b011, 32'h0400});
    push(2, 32'h0000FFFF, 1'b0, 3'd1, {3'b011, 32'h03FF});
    push(2, 32'h00010000, 1'b0, 3'd0, {3'b000, 32'h0400});
    idle_all();
    repeat (10) @(posedge clk);
    #1;

    latency_check("latency");
    repeat (4) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) push(0, 32'(i + 1), 1'b0, 3'd0, {3'b000, ival[i]});
        idle_all();
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!b32.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          chk("throughput_valid", 35'(b32.out_valid), 35'(1));
          @(negedge clk);
        end
        chk("throughput_end", 35'(b32.out_valid), 35'(0));
      end
    join
    repeat (4) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) push(0, 32'(i + 1), 1'b0, 3'd0, {3'b000, ival[i]});
        idle_all();
      end
      begin
        repeat (2) @(posedge clk);
        #1 b32.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 35'(b32.in_ready), 35'(0));
        @(posedge clk);
        #1 b32.out_ready = 1'b1;
        #1 chk("bp_in_ready_rise", 35'(b32.in_ready), 35'(1));
      end
    join
    repeat (15) @(posedge clk);
    #1;
    chk("bp_drained", 35'(q32.size()), 35'(0));

    b32.out_ready = 1'b0;
    push(0, 32'd1, 1'b0, 3'd0, {3'b000, 32'h3F800000});
    push(0, 32'd2, 1'b0, 3'd0, {3'b000, 32'h40000000});
    push(0, 32'd3, 1'b0, 3'd0, {3'b000, 32'h40400000});
    idle_all();
    chk("full_out_valid", 35'(b32.out_valid), 35'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 35'(b32.out_valid), 35'(0));
    chk("rst_out", {b32.out_flags, b32.out_data}, 35'(0));
    q32.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    b32.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 35'(b32.in_ready), 35'(1));
    for (int k = 0; k < 5; k++) begin
      chk("no_stale", 35'(b32.out_valid), 35'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    latency_check("post_rst_latency");
    repeat (6) @(posedge clk);
    #1;

    chk("q32_empty", 35'(q32.size()), 35'(0));
    chk("q16a_empty", 35'(q16a.size()), 35'(0));
    chk("q16b_empty", 35'(q16b.size()), 35'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
